// File: rtl/video_timing_pkg.sv
// ---------------------------------------------------------------------------
// video_timing_pkg
// Shared types and constants for the HDMI video mode controller:
//   - mode encodings (1080p60 / 720p60 / 480p60 / reserved)
//   - controller FSM state encoding
//   - the 24 horizontal/vertical timing constants of the three modes,
//     packed into a timing_t record that is passed to the timing generator
// ---------------------------------------------------------------------------
package video_timing_pkg;

  localparam int TW = 12;

  typedef enum logic [1:0] {
    MODE_1080P = 2'd0,
    MODE_720P  = 2'd1,
    MODE_480P  = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_VB = 3'd1,
    ST_HOLD    = 3'd2,
    ST_LOAD    = 3'd3,
    ST_RELEASE = 3'd4,
    ST_SETTLE  = 3'd5
  } state_e;

  // One complete mode: four horizontal then four vertical values
  typedef struct packed {
    logic [TW-1:0] h_total;
    logic [TW-1:0] h_sync;
    logic [TW-1:0] h_start;
    logic [TW-1:0] h_end;
    logic [TW-1:0] v_total;
    logic [TW-1:0] v_sync;
    logic [TW-1:0] v_start;
    logic [TW-1:0] v_end;
  } timing_t;

  // 1080p60
  localparam logic [TW-1:0] M0_H_TOTAL = 12'd2199;
  localparam logic [TW-1:0] M0_H_SYNC  = 12'd43;
  localparam logic [TW-1:0] M0_H_START = 12'd189;
  localparam logic [TW-1:0] M0_H_END   = 12'd2109;
  localparam logic [TW-1:0] M0_V_TOTAL = 12'd1124;
  localparam logic [TW-1:0] M0_V_SYNC  = 12'd4;
  localparam logic [TW-1:0] M0_V_START = 12'd40;
  localparam logic [TW-1:0] M0_V_END   = 12'd1120;

  // 720p60
  localparam logic [TW-1:0] M1_H_TOTAL = 12'd1649;
  localparam logic [TW-1:0] M1_H_SYNC  = 12'd39;
  localparam logic [TW-1:0] M1_H_START = 12'd257;
  localparam logic [TW-1:0] M1_H_END   = 12'd1537;
  localparam logic [TW-1:0] M1_V_TOTAL = 12'd749;
  localparam logic [TW-1:0] M1_V_SYNC  = 12'd4;
  localparam logic [TW-1:0] M1_V_START = 12'd24;
  localparam logic [TW-1:0] M1_V_END   = 12'd744;

  // 480p60
  localparam logic [TW-1:0] M2_H_TOTAL = 12'd857;
  localparam logic [TW-1:0] M2_H_SYNC  = 12'd61;
  localparam logic [TW-1:0] M2_H_START = 12'd119;
  localparam logic [TW-1:0] M2_H_END   = 12'd839;
  localparam logic [TW-1:0] M2_V_TOTAL = 12'd524;
  localparam logic [TW-1:0] M2_V_SYNC  = 12'd5;
  localparam logic [TW-1:0] M2_V_START = 12'd35;
  localparam logic [TW-1:0] M2_V_END   = 12'd515;

  localparam timing_t MODE0_TIMING = '{M0_H_TOTAL, M0_H_SYNC, M0_H_START, M0_H_END,
                                       M0_V_TOTAL, M0_V_SYNC, M0_V_START, M0_V_END};
  localparam timing_t MODE1_TIMING = '{M1_H_TOTAL, M1_H_SYNC, M1_H_START, M1_H_END,
                                       M1_V_TOTAL, M1_V_SYNC, M1_V_START, M1_V_END};
  localparam timing_t MODE2_TIMING = '{M2_H_TOTAL, M2_H_SYNC, M2_H_START, M2_H_END,
                                       M2_V_TOTAL, M2_V_SYNC, M2_V_START, M2_V_END};

  // True for the three modes that have a timing table entry
  function automatic logic is_valid_mode(input logic [1:0] mode);
    return mode != MODE_RSVD;
  endfunction

endpackage

// File: rtl/video_timing_rom.sv
// ---------------------------------------------------------------------------
// video_timing_rom
// Combinational lookup of the eight 12-bit timing values for a video mode.
// Ports:
//   mode    in  2        mode to look up
//   timing  out timing_t eight timing values for that mode
// The reserved encoding returns the 1080p60 entry; the controller never
// loads it because reserved requests are rejected before a switch starts.
// ---------------------------------------------------------------------------
module video_timing_rom
  import video_timing_pkg::*;
(
  input  logic [1:0] mode,
  output timing_t    timing
);

  // Mode-to-timing table
  always_comb begin
    timing = MODE0_TIMING;
    case (mode)
      MODE_720P: timing = MODE1_TIMING;
      MODE_480P: timing = MODE2_TIMING;
      default:   timing = MODE0_TIMING;
    endcase
  end

endmodule

// File: rtl/video_mode_ctrl.sv
// ---------------------------------------------------------------------------
// video_mode_ctrl
// Holds the active video mode's timing and drives it to the HDMI sync/DE
// timing generator. Mode switches are made glitch-free at frame boundaries:
// blank the output, hold the generator in reset, load the new timing,
// release, wait a few frames to settle, then acknowledge.
// Ports:
//   clk         in   1   pixel clock
//   reset       in   1   asynchronous, active-high reset
//   mode_req    in   1   one-cycle request strobe
//   mode_sel    in   2   requested mode (0=1080p60, 1=720p60, 2=480p60, 3=reserved)
//   vs_in       in   1   generator vsync, active-low, same clock domain
//   h_total .. h_end    out 12  horizontal timing to the generator
//   v_total .. v_end    out 12  vertical timing to the generator
//   tg_reset_n  out  1   generator reset, active-low
//   blank       out  1   forces downstream pixel data / DE to zero
//   busy        out  1   switch in progress
//   mode_ack    out  1   one-cycle pulse: request completed
//   mode_err    out  1   one-cycle pulse: reserved-mode request rejected
//   cur_mode    out  2   mode currently loaded
// ---------------------------------------------------------------------------
module video_mode_ctrl
  import video_timing_pkg::*;
#(
  parameter int HOLD_CYCLES   = 16,
  parameter int SETTLE_FRAMES = 2,
  parameter int VB_TIMEOUT    = 2500000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mode_req,
  input  logic [1:0]    mode_sel,
  input  logic          vs_in,
  output logic [TW-1:0] h_total,
  output logic [TW-1:0] h_sync,
  output logic [TW-1:0] h_start,
  output logic [TW-1:0] h_end,
  output logic [TW-1:0] v_total,
  output logic [TW-1:0] v_sync,
  output logic [TW-1:0] v_start,
  output logic [TW-1:0] v_end,
  output logic          tg_reset_n,
  output logic          blank,
  output logic          busy,
  output logic          mode_ack,
  output logic          mode_err,
  output logic [1:0]    cur_mode
);

  localparam int TMO_W  = $clog2(VB_TIMEOUT) + 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;

  localparam logic [TMO_W-1:0]  TMO_LAST    = TMO_W'(VB_TIMEOUT - 1);
  // The generator reset pulse spans HOLD plus the single LOAD cycle, so
  // HOLD itself lasts one cycle less than the full reset-hold length.
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 2);
  localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE_FRAMES - 1);

  state_e            state;
  state_e            next_state;
  logic              vs_d;
  logic              frame_start;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [3:0]        frame_cnt;
  logic              pend_valid;
  logic [1:0]        pend_sel;
  logic [1:0]        target_mode;
  logic              post_reset;
  logic [1:0]        cur_mode_q;
  timing_t           timing_q;
  timing_t           rom_timing;
  logic              tg_q;
  logic              blank_q;
  logic              busy_q;
  logic              ack_q;
  logic              err_q;

  logic              req_valid;
  logic [1:0]        req_sel;
  logic              take_req;
  logic              ack_next;
  logic              err_next;

  video_timing_rom u_rom (
    .mode   (target_mode),
    .timing (rom_timing)
  );

  // A held request takes priority over a fresh strobe in IDLE; the fresh
  // strobe then lands in the pending slot instead of being lost.
  assign req_valid = pend_valid | mode_req;
  assign req_sel   = pend_valid ? pend_sel : mode_sel;

  // Next-state and one-cycle pulse decode
  always_comb begin
    next_state = state;
    take_req   = 1'b0;
    ack_next   = 1'b0;
    err_next   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (!is_valid_mode(req_sel)) begin
            err_next = 1'b1;
          end else if (req_sel == cur_mode_q) begin
            ack_next = 1'b1;
          end else begin
            take_req   = 1'b1;
            next_state = ST_WAIT_VB;
          end
        end
      end
      ST_WAIT_VB: begin
        if (frame_start || (tmo_cnt == TMO_LAST)) next_state = ST_HOLD;
      end
      ST_HOLD: begin
        if (hold_cnt == HOLD_LAST) next_state = ST_LOAD;
      end
      ST_LOAD:    next_state = ST_RELEASE;
      ST_RELEASE: next_state = ST_SETTLE;
      ST_SETTLE: begin
        if (frame_start && (frame_cnt == SETTLE_LAST)) begin
          next_state = ST_IDLE;
          ack_next   = ~post_reset;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // State register; reset lands in RELEASE so the generator is released and
  // allowed to settle exactly as after a normal switch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RELEASE;
    else       state <= next_state;
  end

  // vsync falling-edge detect, registered; vs_d resets high so reset
  // release never looks like an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_d        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      vs_d        <= vs_in;
      frame_start <= vs_d & ~vs_in;
    end
  end

  // Counters are held at zero outside their own state, which clears them
  // on entry; each saturates at its terminal value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt   <= '0;
      hold_cnt  <= '0;
      frame_cnt <= '0;
    end else begin
      if (state != ST_WAIT_VB)  tmo_cnt <= '0;
      else if (tmo_cnt != TMO_LAST) tmo_cnt <= tmo_cnt + 1'b1;

      if (state != ST_HOLD)     hold_cnt <= '0;
      else if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + 1'b1;

      if (state != ST_SETTLE)   frame_cnt <= '0;
      else if (frame_start && (frame_cnt != SETTLE_LAST)) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  // One-deep pending slot: any strobe outside IDLE (or while the slot is
  // being consumed) overwrites it; IDLE consumes it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_sel   <= 2'd0;
    end else if (mode_req && ((state != ST_IDLE) || pend_valid)) begin
      pend_valid <= 1'b1;
      pend_sel   <= mode_sel;
    end else if (state == ST_IDLE) begin
      pend_valid <= 1'b0;
    end
  end

  // Target latch and post-reset flag that suppresses the first ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target_mode <= MODE_1080P;
      post_reset  <= 1'b1;
    end else begin
      if (take_req) target_mode <= req_sel;
      if ((state == ST_SETTLE) && (next_state == ST_IDLE)) post_reset <= 1'b0;
    end
  end

  // Timing and cur_mode are loaded on the edge into LOAD, so the new values
  // appear while the generator is still held in reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timing_q   <= MODE0_TIMING;
      cur_mode_q <= MODE_1080P;
    end else if ((state == ST_HOLD) && (next_state == ST_LOAD)) begin
      timing_q   <= rom_timing;
      cur_mode_q <= target_mode;
    end
  end

  // Registered control outputs, decoded from the state being entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tg_q    <= 1'b0;
      blank_q <= 1'b1;
      busy_q  <= 1'b1;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      tg_q    <= ~(next_state inside {ST_HOLD, ST_LOAD});
      blank_q <= (next_state != ST_IDLE);
      busy_q  <= (next_state != ST_IDLE);
      ack_q   <= ack_next;
      err_q   <= err_next;
    end
  end

  assign h_total    = timing_q.h_total;
  assign h_sync     = timing_q.h_sync;
  assign h_start    = timing_q.h_start;
  assign h_end      = timing_q.h_end;
  assign v_total    = timing_q.v_total;
  assign v_sync     = timing_q.v_sync;
  assign v_start    = timing_q.v_start;
  assign v_end      = timing_q.v_end;
  assign tg_reset_n = tg_q;
  assign blank      = blank_q;
  assign busy       = busy_q;
  assign mode_ack   = ack_q;
  assign mode_err   = err_q;
  assign cur_mode   = cur_mode_q;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_video_mode_ctrl
// Self-checking bench for video_mode_ctrl. A main instance sees vsync toggling
// every 1000 clocks; a second instance with a short frame-start timeout has
// its vsync held high to exercise the forced switch.
// ---------------------------------------------------------------------------
module tb_video_mode_ctrl;

  localparam int HOLD_CYCLES   = 16;
  localparam int SETTLE_FRAMES = 2;
  localparam int VB_TIMEOUT    = 5000;
  localparam int TMO_SHORT     = 100;

  localparam int EXP_NONE = 0;
  localparam int EXP_ACK  = 1;
  localparam int EXP_ERR  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        mode_req;
  logic [1:0]  mode_sel;
  logic        vs_in;
  logic [11:0] h_total, h_sync, h_start, h_end, v_total, v_sync, v_start, v_end;
  logic        tg_reset_n, blank, busy, mode_ack, mode_err;
  logic [1:0]  cur_mode;

  logic        req_t;
  logic [1:0]  sel_t;
  logic        tmo_hold;
  logic        vs_t;
  logic [11:0] h_total_t, h_sync_t, h_start_t, h_end_t, v_total_t, v_sync_t, v_start_t, v_end_t;
  logic        tg_reset_n_t, blank_t, busy_t, ack_t, err_t;
  logic [1:0]  cur_mode_t;

  int checks   = 0;
  int failures = 0;
  int vs_falls = 0;

  typedef struct {
    int is_err;
    int mode;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  assign vs_t = tmo_hold ? 1'b1 : vs_in;

  video_mode_ctrl #(
    .HOLD_CYCLES(HOLD_CYCLES), .SETTLE_FRAMES(SETTLE_FRAMES), .VB_TIMEOUT(VB_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .mode_req(mode_req), .mode_sel(mode_sel), .vs_in(vs_in),
    .h_total(h_total), .h_sync(h_sync), .h_start(h_start), .h_end(h_end),
    .v_total(v_total), .v_sync(v_sync), .v_start(v_start), .v_end(v_end),
    .tg_reset_n(tg_reset_n), .blank(blank), .busy(busy),
    .mode_ack(mode_ack), .mode_err(mode_err), .cur_mode(cur_mode)
  );

  video_mode_ctrl #(
    .HOLD_CYCLES(HOLD_CYCLES), .SETTLE_FRAMES(SETTLE_FRAMES), .VB_TIMEOUT(TMO_SHORT)
  ) dut_tmo (
    .clk(clk), .reset(reset), .mode_req(req_t), .mode_sel(sel_t), .vs_in(vs_t),
    .h_total(h_total_t), .h_sync(h_sync_t), .h_start(h_start_t), .h_end(h_end_t),
    .v_total(v_total_t), .v_sync(v_sync_t), .v_start(v_start_t), .v_end(v_end_t),
    .tg_reset_n(tg_reset_n_t), .blank(blank_t), .busy(busy_t),
    .mode_ack(ack_t), .mode_err(err_t), .cur_mode(cur_mode_t)
  );

  // Reference timing values per mode
  function automatic int exp_h_total(input int m);
    case (m)
      1:       return 1649;
      2:       return 857;
      default: return 2199;
    endcase
  endfunction

  function automatic int exp_v_end(input int m);
    case (m)
      1:       return 744;
      2:       return 515;
      default: return 1120;
    endcase
  endfunction

  task automatic check_output(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle request on the main instance, queueing the response
  task automatic apply_stimulus(input logic [1:0] sel, input int expect_kind);
    exp_t e;
    if (expect_kind != EXP_NONE) begin
      e.is_err = (expect_kind == EXP_ERR) ? 1 : 0;
      e.mode   = int'(sel);
      sb_q.push_back(e);
    end
    mode_req = 1'b1;
    mode_sel = sel;
    next_cycle();
    mode_req = 1'b0;
  endtask

  // Returns on the cycle in which the registered frame start is high
  task automatic wait_frame_start(input string tag);
    int start_cnt;
    int seen;
    start_cnt = vs_falls;
    seen = 0;
    for (int i = 0; i < 2500 && seen == 0; i++) begin
      next_cycle();
      if (vs_falls != start_cnt) seen = 1;
    end
    check_output({tag, "_seen"}, seen, 1);
  endtask

  task automatic wait_ack(input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < 8000 && seen == 0; i++) begin
      next_cycle();
      if (mode_ack) seen = 1;
    end
    check_output({tag, "_seen"}, seen, 1);
  endtask

  // vsync: toggles every 1000 clocks, changed 2 time units after the edge
  initial begin
    vs_in = 1'b1;
    forever begin
      repeat (1000) @(posedge clk);
      #2;
      vs_in = ~vs_in;
      if (!vs_in) vs_falls++;
    end
  end

  // Scoreboard: every ack/err pulse of the main instance pops one entry
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && (mode_ack || mode_err)) begin
        if (sb_q.size() == 0) begin
          check_output("sb_underflow", sb_q.size(), 1);
        end else begin
          e = sb_q.pop_front();
          check_output("sb_is_err", int'(mode_err), e.is_err);
          check_output("sb_is_ack", int'(mode_ack), 1 - e.is_err);
          if (e.is_err == 0) begin
            check_output("sb_cur_mode", int'(cur_mode), e.mode);
            check_output("sb_h_total", int'(h_total), exp_h_total(e.mode));
            check_output("sb_v_end", int'(v_end), exp_v_end(e.mode));
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int low_cnt;
    int h_seen;
    int v_seen;
    int n;

    reset    = 1'b0;
    mode_req = 1'b0;
    mode_sel = 2'd0;
    req_t    = 1'b0;
    sel_t    = 2'd0;
    tmo_hold = 1'b0;
    #2;
    reset = 1'b1;
    repeat (3) next_cycle();

    // Reset values
    check_output("rst_h_total", int'(h_total), 2199);
    check_output("rst_v_end", int'(v_end), 1120);
    check_output("rst_cur_mode", int'(cur_mode), 0);
    check_output("rst_tg_reset_n", int'(tg_reset_n), 0);
    check_output("rst_blank", int'(blank), 1);
    check_output("rst_busy", int'(busy), 1);
    check_output("rst_ack_err", int'({mode_ack, mode_err}), 0);

    // Post-reset release and settle, no ack
    reset = 1'b0;
    next_cycle();
    check_output("rel_tg_reset_n", int'(tg_reset_n), 1);
    check_output("rel_blank", int'(blank), 1);
    wait_frame_start("rst_fs1");
    next_cycle();
    check_output("rst_fs1_blank", int'(blank), 1);
    wait_frame_start("rst_fs2");
    next_cycle();
    check_output("rst_fs2_blank", int'(blank), 0);
    check_output("rst_fs2_busy", int'(busy), 0);
    check_output("rst_fs2_no_ack", int'(mode_ack), 0);
    check_output("rst_fs2_h_total", int'(h_total), 2199);

    // Switch to 720p
    apply_stimulus(2'd1, EXP_ACK);
    check_output("sw1_busy", int'(busy), 1);
    check_output("sw1_blank", int'(blank), 1);
    check_output("sw1_tg_before", int'(tg_reset_n), 1);
    wait_frame_start("sw1_fs");
    check_output("sw1_tg_at_fs", int'(tg_reset_n), 1);
    check_output("sw1_h_at_fs", int'(h_total), 2199);
    low_cnt = 0;
    h_seen  = 0;
    v_seen  = 0;
    for (int i = 0; i < 100; i++) begin
      next_cycle();
      if (tg_reset_n) break;
      low_cnt++;
      h_seen = int'(h_total);
      v_seen = int'(v_end);
    end
    check_output("sw1_tg_low_len", low_cnt, HOLD_CYCLES);
    check_output("sw1_h_in_reset", h_seen, 1649);
    check_output("sw1_v_in_reset", v_seen, 744);
    check_output("sw1_cur_mode", int'(cur_mode), 1);
    wait_frame_start("sw1_settle1");
    next_cycle();
    check_output("sw1_settle1_ack", int'(mode_ack), 0);
    check_output("sw1_settle1_blank", int'(blank), 1);
    wait_frame_start("sw1_settle2");
    next_cycle();
    check_output("sw1_ack", int'(mode_ack), 1);
    check_output("sw1_done_blank", int'(blank), 0);
    check_output("sw1_done_busy", int'(busy), 0);

    // Same-mode request and reserved request while idle in 720p
    apply_stimulus(2'd1, EXP_ACK);
    check_output("same_ack", int'(mode_ack), 1);
    check_output("same_tg", int'(tg_reset_n), 1);
    check_output("same_blank", int'(blank), 0);
    check_output("same_busy", int'(busy), 0);
    apply_stimulus(2'd3, EXP_ERR);
    check_output("rsvd_err", int'(mode_err), 1);
    check_output("rsvd_no_ack", int'(mode_ack), 0);
    check_output("rsvd_busy", int'(busy), 0);
    check_output("rsvd_cur_mode", int'(cur_mode), 1);

    // Back to 1080p so the pending test starts with a switch to 720p
    apply_stimulus(2'd0, EXP_ACK);
    wait_ack("to_mode0");
    check_output("to_mode0_cur", int'(cur_mode), 0);

    // Pending slot: sel 2 is overwritten by sel 0 before the first switch ends
    apply_stimulus(2'd1, EXP_ACK);
    repeat (5) next_cycle();
    apply_stimulus(2'd2, EXP_NONE);
    repeat (5) next_cycle();
    apply_stimulus(2'd0, EXP_ACK);
    wait_ack("pend_ack1");
    check_output("pend_ack1_mode", int'(cur_mode), 1);
    next_cycle();
    check_output("pend_restart_busy", int'(busy), 1);
    check_output("pend_restart_blank", int'(blank), 1);
    wait_ack("pend_ack0");
    check_output("pend_ack0_mode", int'(cur_mode), 0);
    repeat (20) next_cycle();
    check_output("pend_drained_busy", int'(busy), 0);

    // Forced switch on the short-timeout instance with vsync held high
    tmo_hold = 1'b1;
    repeat (3) next_cycle();
    sel_t = 2'd2;
    req_t = 1'b1;
    next_cycle();
    req_t = 1'b0;
    check_output("tmo_busy", int'(busy_t), 1);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      next_cycle();
      n++;
      if (!tg_reset_n_t) break;
    end
    check_output("tmo_hold_entry", n, TMO_SHORT);
    for (int i = 0; i < 50; i++) begin
      if (tg_reset_n_t) break;
      next_cycle();
    end
    check_output("tmo_tg_released", int'(tg_reset_n_t), 1);
    check_output("tmo_h_total", int'(h_total_t), 857);
    check_output("tmo_cur_mode", int'(cur_mode_t), 2);

    // Reset asserted during HOLD with a request pending
    apply_stimulus(2'd2, EXP_NONE);
    wait_frame_start("rh_fs");
    repeat (4) next_cycle();
    check_output("rh_in_hold", int'(tg_reset_n), 0);
    apply_stimulus(2'd1, EXP_NONE);
    reset = 1'b1;
    #1;
    check_output("rh_h_total", int'(h_total), 2199);
    check_output("rh_v_end", int'(v_end), 1120);
    check_output("rh_cur_mode", int'(cur_mode), 0);
    check_output("rh_blank", int'(blank), 1);
    next_cycle();
    check_output("rh_tg", int'(tg_reset_n), 0);
    check_output("rh_ack_err", int'({mode_ack, mode_err}), 0);
    reset = 1'b0;
    wait_frame_start("rh_fs1");
    wait_frame_start("rh_fs2");
    next_cycle();
    check_output("rh_idle_busy", int'(busy), 0);
    check_output("rh_idle_ack", int'(mode_ack), 0);
    repeat (10) next_cycle();
    check_output("rh_pend_cleared", int'(busy), 0);
    check_output("rh_final_mode", int'(cur_mode), 0);

    check_output("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
